// File: rtl/image_control_if.sv
// Signal bundle between image_control, its incoming pixel stream, four line buffers and the
// downstream window consumer.
interface image_control_if;
    logic [3:0]  i_pixel;
    logic        i_pixel_valid;
    logic        o_ready;
    logic [3:0]  o_lb_pixel;
    logic [3:0]  o_lb_wr_en;
    logic [3:0]  o_lb_rd_en;
    logic [47:0] i_lb_data;
    logic [35:0] o_window;
    logic        o_window_valid;
    logic        o_line_done;
    logic        o_wr_gap_err;

    modport master (
        input  i_pixel, i_pixel_valid, i_lb_data,
        output o_ready, o_lb_pixel, o_lb_wr_en, o_lb_rd_en,
        output o_window, o_window_valid, o_line_done, o_wr_gap_err
    );

    modport slave (
        output i_pixel, i_pixel_valid, i_lb_data,
        input  o_ready, o_lb_pixel, o_lb_wr_en, o_lb_rd_en,
        input  o_window, o_window_valid, o_line_done, o_wr_gap_err
    );
endinterface

// File: rtl/image_control.sv
// Rotates incoming lines across four line buffers and reads the three oldest in lockstep to
// build a 3x3 pixel window for the convolution stage.
module image_control #(
    parameter int unsigned LINE_W = 400,
    parameter int unsigned CNT_W  = 11
) (
    input logic             clk,
    input logic             reset,
    image_control_if.master bus
);
    localparam int unsigned PtrW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [PtrW-1:0]  LastIdx = PtrW'(LINE_W - 1);
    localparam logic [CNT_W-1:0] FullLvl = CNT_W'(4 * LINE_W);
    localparam logic [CNT_W-1:0] ReadLvl = CNT_W'(3 * LINE_W);

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e           state_q, state_d;
    logic [1:0]       wr_sel_q, wr_sel_d;
    logic [1:0]       rd_sel_q, rd_sel_d;
    logic [1:0]       win_sel_q;
    logic [PtrW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [PtrW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] stored_q, stored_d;
    logic             win_valid_q;
    logic             line_done_q;
    logic             gap_err_q;

    logic             ready;
    logic             accept;
    logic             reading;
    logic [3:0]       rd_en;
    logic [3:0]       wr_en;
    logic [1:0]       win_sel1, win_sel2;
    logic [11:0]      slot [4];
    logic [35:0]      window;

    assign ready   = stored_q < FullLvl;
    assign accept  = bus.i_pixel_valid & ready;
    assign reading = (state_q == StRead);

    // Write path: one-hot steer into the buffer currently being filled.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_sel_d = wr_sel_q;
        wr_en    = '0;
        if (accept) begin
            wr_en = 4'b0001 << wr_sel_q;
            if (wr_cnt_q == LastIdx) begin
                wr_cnt_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + PtrW'(1);
            end
        end
    end

    always_comb begin
        stored_d = stored_q;
        if (accept && !reading) begin
            stored_d = stored_q + CNT_W'(1);
        end else if (!accept && reading) begin
            stored_d = stored_q - CNT_W'(1);
        end
    end

    // Read sequencer: one full row per READ visit, always returning to IDLE for a cycle.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rd_sel_d = rd_sel_q;
        rd_en    = '0;
        case (state_q)
            StIdle: begin
                if (stored_q >= ReadLvl) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                // Three consecutive buffers from rd_sel; the one just before rd_sel is skipped.
                rd_en = ~(4'b0001 << (rd_sel_q + 2'd3));
                if (rd_cnt_q == LastIdx) begin
                    rd_cnt_d = '0;
                    rd_sel_d = rd_sel_q + 2'd1;
                    state_d  = StIdle;
                end else begin
                    rd_cnt_d = rd_cnt_q + PtrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_sel_q    <= '0;
            rd_sel_q    <= '0;
            win_sel_q   <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            stored_q    <= '0;
            win_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            gap_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            stored_q    <= stored_d;
            win_valid_q <= reading;
            // Buffer data lags rd_en by a cycle, so the select follows rd_sel one cycle late.
            if (reading) begin
                win_sel_q <= rd_sel_q;
            end
            line_done_q <= win_valid_q & ~reading;
            if (!bus.i_pixel_valid && (wr_cnt_q != '0)) begin
                gap_err_q <= 1'b1;
            end
        end
    end

    assign win_sel1 = win_sel_q + 2'd1;
    assign win_sel2 = win_sel_q + 2'd2;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            slot[k] = bus.i_lb_data[12*k +: 12];
        end
    end

    always_comb begin
        window = '0;
        if (win_valid_q) begin
            window = {slot[win_sel_q], slot[win_sel1], slot[win_sel2]};
        end
    end

    assign bus.o_ready        = ready;
    assign bus.o_lb_pixel     = bus.i_pixel;
    assign bus.o_lb_wr_en     = wr_en;
    assign bus.o_lb_rd_en     = rd_en;
    assign bus.o_window       = window;
    assign bus.o_window_valid = win_valid_q;
    assign bus.o_line_done    = line_done_q;
    assign bus.o_wr_gap_err   = gap_err_q;
endmodule

// File: tb/tb_image_control.sv
// Directed bench for image_control with LINE_W=8 and a behavioural model of four line buffers.
module tb_image_control;
    localparam int NV = 90;

    typedef struct {
        logic        valid;
        logic [3:0]  pix;
        logic [3:0]  wr_en;
        logic [3:0]  rd_en;
        logic        wvalid;
        logic [35:0] win;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    image_control_if bus ();

    image_control #(.LINE_W(8), .CNT_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Line buffer model: registered {left, centre, right} with zero padding at the line ends.
    logic [3:0]  mem   [4][8];
    logic [2:0]  wptr  [4];
    logic [2:0]  rptr  [4];
    logic [11:0] dout  [4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
                dout[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.o_lb_wr_en[k]) begin
                    mem[k][wptr[k]] <= bus.o_lb_pixel;
                    wptr[k] <= wptr[k] + 3'd1;
                end else begin
                    wptr[k] <= '0;
                end
                if (bus.o_lb_rd_en[k]) begin
                    dout[k] <= {(rptr[k] == 3'd0) ? 4'h0 : mem[k][rptr[k] - 3'd1],
                                mem[k][rptr[k]],
                                (rptr[k] == 3'd7) ? 4'h0 : mem[k][rptr[k] + 3'd1]};
                    rptr[k] <= rptr[k] + 3'd1;
                end else begin
                    rptr[k] <= '0;
                end
            end
        end
    end

    assign bus.i_lb_data = {dout[3], dout[2], dout[1], dout[0]};

    function automatic logic [3:0] pv(input int l, input int q);
        return 4'((8 * l + q) % 16);
    endfunction

    function automatic logic [11:0] seg(input int l, input int p);
        logic [3:0] a;
        logic [3:0] c;
        a = (p > 0) ? pv(l, p - 1) : 4'h0;
        c = (p < 7) ? pv(l, p + 1) : 4'h0;
        return {a, pv(l, p), c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] p);
        bus.i_pixel_valid = v;
        bus.i_pixel       = p;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0);
        reset = 1'b1;
        adv();
        reset = 1'b0;
    endtask

    vec_t        vec [NV];
    logic [3:0]  masks [4];
    int          done_cnt;
    int          wv_cnt;
    int          rd_cnt;

    initial begin
        masks[0] = 4'b0111;
        masks[1] = 4'b1110;
        masks[2] = 4'b1101;
        masks[3] = 4'b1011;
        // 64 contiguous pixels; rows read at cycles 25+9r..32+9r, data one cycle later.
        for (int c = 0; c < NV; c++) begin
            int r;
            int p;
            vec[c].valid  = (c < 64);
            vec[c].pix    = (c < 64) ? 4'(c % 16) : 4'h0;
            vec[c].wr_en  = (c < 64) ? (4'b0001 << ((c / 8) % 4)) : 4'h0;
            vec[c].rd_en  = 4'h0;
            vec[c].wvalid = 1'b0;
            vec[c].win    = '0;
            vec[c].done   = 1'b0;
            if (c >= 25 && ((c - 25) % 9) < 8 && ((c - 25) / 9) < 6) begin
                vec[c].rd_en = masks[((c - 25) / 9) % 4];
            end
            if (c >= 26 && ((c - 26) % 9) < 8 && ((c - 26) / 9) < 6) begin
                r = (c - 26) / 9;
                p = (c - 26) % 9;
                vec[c].wvalid = 1'b1;
                vec[c].win    = {seg(r, p), seg(r + 1, p), seg(r + 2, p)};
            end
            if (c >= 34 && ((c - 34) % 9) == 0 && ((c - 34) / 9) < 6) begin
                vec[c].done = 1'b1;
            end
        end

        reset = 1'b1;
        drive(1'b0, 4'h0);
        @(negedge clk);
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_wr_en", bus.o_lb_wr_en, 0);
        chk("rst_rd_en", bus.o_lb_rd_en, 0);
        chk("rst_wvalid", bus.o_window_valid, 0);
        chk("rst_window", bus.o_window, 0);
        chk("rst_done", bus.o_line_done, 0);
        chk("rst_err", bus.o_wr_gap_err, 0);
        adv();
        reset = 1'b0;

        for (int c = 0; c < NV; c++) begin
            drive(vec[c].valid, vec[c].pix);
            @(negedge clk);
            chk($sformatf("v%0d_lb_pixel", c), bus.o_lb_pixel, vec[c].pix);
            chk($sformatf("v%0d_wr_en", c), bus.o_lb_wr_en, vec[c].wr_en);
            chk($sformatf("v%0d_rd_en", c), bus.o_lb_rd_en, vec[c].rd_en);
            chk($sformatf("v%0d_ready", c), bus.o_ready, 1);
            chk($sformatf("v%0d_wvalid", c), bus.o_window_valid, vec[c].wvalid);
            chk($sformatf("v%0d_window", c), bus.o_window, vec[c].win);
            chk($sformatf("v%0d_done", c), bus.o_line_done, vec[c].done);
            chk($sformatf("v%0d_err", c), bus.o_wr_gap_err, 0);
            adv();
        end

        // Constant lines 1, 2, 3: padded edges and one line_done for the row.
        do_reset();
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            drive(c < 24, (c < 8) ? 4'h1 : (c < 16) ? 4'h2 : (c < 24) ? 4'h3 : 4'h0);
            @(negedge clk);
            if (c == 25) chk("const_rd_en", bus.o_lb_rd_en, 4'b0111);
            if (c == 26) chk("const_first", bus.o_window, 36'h011022033);
            if (c >= 27 && c <= 32) chk("const_mid", bus.o_window, 36'h111222333);
            if (c == 33) chk("const_last", bus.o_window, 36'h110220330);
            if (c == 34) chk("const_done_at", bus.o_line_done, 1);
            done_cnt += int'(bus.o_line_done);
            adv();
        end
        chk("const_done_count", done_cnt, 1);

        // Gap between lines is legal; gap at wr_cnt=3 sets a sticky flag.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'(c));
            adv();
        end
        drive(1'b0, 4'h0);
        adv();
        @(negedge clk);
        chk("gap0_no_err", bus.o_wr_gap_err, 0);
        adv();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'(c));
            adv();
        end
        drive(1'b0, 4'h0);
        @(negedge clk);
        chk("gap3_before", bus.o_wr_gap_err, 0);
        adv();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 4'(c + 3));
            @(negedge clk);
            if (c == 0) chk("gap3_set", bus.o_wr_gap_err, 1);
            adv();
        end
        drive(1'b0, 4'h0);
        for (int c = 0; c < 3; c++) adv();
        @(negedge clk);
        chk("gap3_sticky", bus.o_wr_gap_err, 1);
        adv();

        // Reset in the middle of a row (rd_cnt=4).
        do_reset();
        for (int c = 0; c < 29; c++) begin
            drive(1'b1, 4'(c % 16));
            adv();
        end
        drive(1'b1, 4'(29 % 16));
        #1;
        chk("mid_rd_en", bus.o_lb_rd_en, 4'b0111);
        chk("mid_wvalid", bus.o_window_valid, 1);
        drive(1'b0, 4'h0);
        reset = 1'b1;
        #1;
        chk("arst_ready", bus.o_ready, 1);
        chk("arst_wr_en", bus.o_lb_wr_en, 0);
        chk("arst_rd_en", bus.o_lb_rd_en, 0);
        chk("arst_wvalid", bus.o_window_valid, 0);
        chk("arst_window", bus.o_window, 0);
        chk("arst_done", bus.o_line_done, 0);
        chk("arst_err", bus.o_wr_gap_err, 0);
        adv();
        reset = 1'b0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 4'(c));
            adv();
        end
        wv_cnt = 0;
        rd_cnt = 0;
        drive(1'b0, 4'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            wv_cnt += int'(bus.o_window_valid);
            rd_cnt += int'(bus.o_lb_rd_en != 4'h0);
            adv();
        end
        chk("post_rst_no_window", wv_cnt, 0);
        chk("post_rst_no_read", rd_cnt, 0);
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'h5);
            adv();
        end
        drive(1'b0, 4'h0);
        @(negedge clk);
        chk("post_rst_wv_k1", bus.o_window_valid, 0);
        adv();
        @(negedge clk);
        chk("post_rst_wv_k2", bus.o_window_valid, 0);
        chk("post_rst_rd_en", bus.o_lb_rd_en, 4'b0111);
        adv();
        @(negedge clk);
        chk("post_rst_wv_k3", bus.o_window_valid, 1);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/image_control.md
Name: image_control

Overview:
- Sequencer on the initiator side of the line-buffer write/read interface; it sits between the incoming 4-bit pixel stream and four `linebuffer` instances.
- Steers each incoming line into one of four buffers in rotation.
- Once three full lines are stored, it reads those three buffers in lockstep and presents a 3x3 pixel window (36 bits) with a valid flag to the downstream convolution stage.
- Retires the oldest line after every row of windows.

Parameters:
- LINE_W, 400, pixels per line; must equal the depth of each attached line buffer (N+1).
- CNT_W, 11, width of the stored-pixel counter; must hold 4*LINE_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_pixel  in  4  incoming pixel.
- i_pixel_valid  in  1  i_pixel is valid this cycle.
- o_ready  out  1  block accepts a pixel this cycle.
- o_lb_pixel  out  4  pixel broadcast to all four line buffers.
- o_lb_wr_en  out  4  one-hot write enable, bit k drives buffer k.
- o_lb_rd_en  out  4  read enables; exactly three bits set while reading.
- i_lb_data  in  48  {buf3,buf2,buf1,buf0} 12-bit 3-pixel outputs.
- o_window  out  36  {top row, middle row, bottom row}, 12 bits each.
- o_window_valid  out  1  o_window is valid this cycle.
- o_line_done  out  1  one-cycle pulse when a row of windows completes.
- o_wr_gap_err  out  1  sticky flag: write gap inside a line.

Behaviour:
- Reset (async, active-high): wr_sel=0, rd_sel=0, wr_cnt=0, rd_cnt=0, stored=0, FSM=IDLE.
  - All outputs are 0 except o_ready=1.
- Write path:
  - Accept = i_pixel_valid & o_ready.
  - o_lb_pixel = i_pixel (combinational).
  - o_lb_wr_en = accept ? (1<<wr_sel) : 0.
  - wr_cnt increments per accept. At LINE_W-1 it wraps to 0 and wr_sel advances (mod 4, 3->0).
- Line buffers reset their write pointer when wr_en drops, so each line must arrive as an unbroken burst.
  - If i_pixel_valid is low while 0 < wr_cnt < LINE_W, o_wr_gap_err sets.
  - The flag clears only on reset. Data is not repaired.
- stored counter (CNT_W bits) update per cycle:
  - +1 on accept.
  - -1 on each READ-state cycle.
  - Unchanged when both occur.
- o_ready = (stored < 4*LINE_W).
  - A pixel presented while o_ready=0 is dropped. It is neither counted nor flagged.
- FSM states:
  - IDLE: o_lb_rd_en=0. Go to READ when stored >= 3*LINE_W, checked on the registered value.
  - READ: o_lb_rd_en bits rd_sel, rd_sel+1, rd_sel+2 (mod 4) are 1; the remaining bit is 0.
    - rd_cnt increments per cycle.
    - When rd_cnt==LINE_W-1: rd_cnt->0, rd_sel advances mod 4, state->IDLE.
- rd_en stays high for exactly LINE_W consecutive cycles per row; it is never deasserted mid-row.
  - At least one IDLE cycle separates consecutive rows.
- The buffer at wr_sel is never among the three read buffers while reading. This follows from the 3*LINE_W threshold and the rotation.
- Output latency: buffer data is registered one cycle after rd_en.
  - o_window_valid = READ state delayed 1 cycle.
  - The mux select is rd_sel captured at READ entry, held through the last data cycle.
  - o_window = {buf[sel], buf[sel+1], buf[sel+2]} (mod 4), with the oldest line on top.
  - o_window is 0 when o_window_valid=0.
- o_line_done pulses on the cycle after the last o_window_valid of a row.
- Reset mid-row: all state clears immediately. After reset, the first READ needs three fresh full lines.

Test Plan:
- LINE_W=8. Stream 24 contiguous pixels (values 0..15 cyclic) -> o_lb_wr_en = 0001, 0010, 0100 for 8 cycles each; READ entered after 24th accept; o_lb_rd_en=0111 for 8 cycles; o_window_valid high 8 cycles, one cycle later.
- Continue streaming to 48 pixels -> second read uses rd_en=1110; third uses 1101 (buffers 0,2,3), with the oldest line (buf2) in o_window[35:24].
- Lines of constant values 1, 2, 3 -> each middle window = 36'h111_222_333; first window = 36'h011_022_033; last window = 36'h110_220_330; o_line_done pulses once per row.
- Accept and READ decrement in the same cycle -> stored unchanged, checked via o_ready staying 1 through 64 continuous pixels.
- Drop i_pixel_valid for one cycle at wr_cnt=3 -> o_wr_gap_err=1 and stays 1; gap at wr_cnt=0 -> no flag.
- Assert reset during READ at rd_cnt=4 -> all outputs 0 asynchronously, o_ready=1; 24 new pixels are needed before the next o_window_valid.
